// File: rtl/distributor_pkg.sv
// Shared definitions for the packet distributor: FSM states and header field positions.
package distributor_pkg;

    typedef enum logic [1:0] {
        HDR_RX = 2'd0,
        HDR_TX = 2'd1,
        PAY_RX = 2'd2,
        PAY_TX = 2'd3
    } state_t;

    // Payload length field inside the header word.
    localparam int LEN_LSB = 0;
    localparam int LEN_MSB = 7;

    // Destination select lives in the top bit of the header (DEST_BIT = WIDTH-1).
    function automatic int dest_bit(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/distributor.sv
// Packet distributor: routes a header word and its N payload words to one of two
// output ports, chosen by the header's top bit. One word is buffered at a time.
module distributor
    import distributor_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] input_a,
    input  logic             input_a_stb,
    output logic             input_a_ack,
    output logic [WIDTH-1:0] output_z,
    output logic             output_z_stb,
    input  logic             output_z_ack,
    output logic [WIDTH-1:0] output_y,
    output logic             output_y_stb,
    input  logic             output_y_ack
);

    localparam int DEST_BIT = dest_bit(WIDTH);

    state_t           state;
    logic [7:0]       remaining;
    logic             dest;
    logic [WIDTH-1:0] hold;

    logic rx_state;
    logic tx_state;
    logic sel_ack;
    logic in_xfer;
    logic out_xfer;

    // Handshake decode; everything visible at the ports comes from registered state,
    // masked by rst so the outputs read zero for the whole reset interval.
    always_comb begin
        rx_state = (state == HDR_RX) || (state == PAY_RX);
        tx_state = (state == HDR_TX) || (state == PAY_TX);
        sel_ack  = dest ? output_y_ack : output_z_ack;
        in_xfer  = input_a_stb && input_a_ack;
        out_xfer = tx_state && sel_ack && !rst;
    end

    // Port drive: data goes to both ports, strobe only to the latched destination.
    always_comb begin
        input_a_ack  = !rst && rx_state;
        output_z_stb = !rst && tx_state && !dest;
        output_y_stb = !rst && tx_state && dest;
        output_z     = rst ? '0 : hold;
        output_y     = rst ? '0 : hold;
    end

    // Packet FSM: alternate receive/transmit per word, counting payload words down.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HDR_RX;
            remaining <= 8'd0;
            dest      <= 1'b0;
            hold      <= '0;
        end else begin
            case (state)
                HDR_RX: if (in_xfer) begin
                    hold      <= input_a;
                    dest      <= input_a[DEST_BIT];
                    remaining <= input_a[LEN_MSB:LEN_LSB];
                    state     <= HDR_TX;
                end
                PAY_RX: if (in_xfer) begin
                    hold      <= input_a;
                    remaining <= remaining - 8'd1;
                    state     <= PAY_TX;
                end
                HDR_TX, PAY_TX: if (out_xfer) begin
                    state <= (remaining != 8'd0) ? PAY_RX : HDR_RX;
                end
                default: state <= HDR_RX;
            endcase
        end
    end

endmodule

// File: tb/tb_distributor.sv
// Scoreboard bench for the distributor: the driver queues the expected word per port
// as it sends, and a monitor pops and compares on every output handshake.
module tb_distributor;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] input_a;
    logic             input_a_stb;
    logic             input_a_ack;
    logic [WIDTH-1:0] output_z;
    logic             output_z_stb;
    logic             output_z_ack;
    logic [WIDTH-1:0] output_y;
    logic             output_y_stb;
    logic             output_y_ack;

    distributor #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .input_a      (input_a),
        .input_a_stb  (input_a_stb),
        .input_a_ack  (input_a_ack),
        .output_z     (output_z),
        .output_z_stb (output_z_stb),
        .output_z_ack (output_z_ack),
        .output_y     (output_y),
        .output_y_stb (output_y_stb),
        .output_y_ack (output_y_ack)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int nz         = 0;
    int ny         = 0;
    int ystb_cnt   = 0;
    int last_xfer  = 0;

    logic [WIDTH-1:0] qz[$];
    logic [WIDTH-1:0] qy[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: inputs only change shortly after posedge, so a handshake seen at
    // negedge is the one that completes on the next rising edge.
    always @(negedge clk) begin
        logic [WIDTH-1:0] e;
        if (rst !== 1'b1) begin
            if (output_y_stb) ystb_cnt++;
            if (output_z_stb && output_z_ack) begin
                nz++;
                last_xfer = cyc + 1;
                if (qz.size() == 0) chk("z_unexpected_word", {16'h0, output_z}, 32'hDEAD_BEEF);
                else begin
                    e = qz.pop_front();
                    chk("z_data", {16'h0, output_z}, {16'h0, e});
                end
            end
            if (output_y_stb && output_y_ack) begin
                ny++;
                last_xfer = cyc + 1;
                if (qy.size() == 0) chk("y_unexpected_word", {16'h0, output_y}, 32'hDEAD_BEEF);
                else begin
                    e = qy.pop_front();
                    chk("y_data", {16'h0, output_y}, {16'h0, e});
                end
            end
        end
    end

    // Present one word and hold it until the DUT accepts it; expected goes to the scoreboard.
    task automatic send_word(input logic [WIDTH-1:0] w, input bit to_y);
        bit got = 0;
        if (to_y) qy.push_back(w); else qz.push_back(w);
        input_a     = w;
        input_a_stb = 1'b1;
        for (int i = 0; i < 500 && !got; i++) begin
            @(negedge clk);
            if (input_a_ack) got = 1;
            @(posedge clk); #1;
        end
        if (!got) chk("input_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic end_pkt();
        input_a_stb = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok = 0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (qz.size() == 0 && qy.size() == 0) ok = 1;
            else begin @(posedge clk); #1; end
        end
        if (!ok) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    int  c0, y0, z0;
    bit  stall_ok;
    bit  seen;
    bit  done;

    initial begin
        rst = 1'b1; input_a = '0; input_a_stb = 1'b0;
        output_z_ack = 1'b0; output_y_ack = 1'b0;
        input_a_stb = 1'b1; input_a = 16'h8123;
        repeat (3) @(posedge clk);
        #2;
        // Reset state: all outputs low even with input strobe high.
        chk("rst_in_ack", {31'd0, input_a_ack}, 32'd0);
        chk("rst_stbs", {30'd0, output_z_stb, output_y_stb}, 32'd0);
        chk("rst_data", {output_z, output_y}, 32'd0);
        input_a_stb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ack", {31'd0, input_a_ack}, 32'd1);

        // Basic z packet at full throughput; y ack held high and must be ignored.
        output_z_ack = 1'b1; output_y_ack = 1'b1;
        c0 = cyc; y0 = ystb_cnt;
        send_word(16'h0003, 0);
        send_word(16'h1111, 0);
        send_word(16'h2222, 0);
        send_word(16'h3333, 0);
        end_pkt();
        wait_drain();
        chk("full_rate_cycles", last_xfer - c0, 32'd8);
        chk("y_stb_while_z", ystb_cnt - y0, 32'd0);

        // Zero-length y packet followed by a short z packet.
        y0 = ny; z0 = nz;
        send_word(16'h8000, 1);
        send_word(16'h0001, 0);
        send_word(16'hABCD, 0);
        end_pkt();
        wait_drain();
        chk("y_count_n0", ny - y0, 32'd1);
        chk("z_count_n1", nz - z0, 32'd2);

        // Stall output_z for 10 cycles while a payload word is presented.
        stall_ok = 1; seen = 0;
        fork
            begin
                send_word(16'h0002, 0);
                send_word(16'hAAAA, 0);
                send_word(16'hBBBB, 0);
                end_pkt();
            end
            begin
                for (int i = 0; i < 200 && !seen; i++) begin
                    @(posedge clk); #2;
                    if (output_z_stb && output_z == 16'hAAAA) begin
                        seen = 1;
                        output_z_ack = 1'b0;
                    end
                end
                for (int i = 0; i < 10; i++) begin
                    @(posedge clk); #2;
                    if (!(output_z_stb === 1'b1 && output_z === 16'hAAAA && input_a_ack === 1'b0))
                        stall_ok = 0;
                end
                output_z_ack = 1'b1;
            end
        join
        wait_drain();
        chk("stall_seen", {31'd0, seen}, 32'd1);
        chk("stall_stable", {31'd0, stall_ok}, 32'd1);

        // Reset in the middle of an N=5 packet after two payload words.
        send_word(16'h0005, 0);
        send_word(16'h0101, 0);
        send_word(16'h0202, 0);
        end_pkt();
        wait_drain();
        rst = 1'b1;
        #1;
        chk("midrst_stbs", {29'd0, input_a_ack, output_z_stb, output_y_stb}, 32'd0);
        @(posedge clk); #2;
        chk("midrst_data", {output_z, output_y}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        y0 = ny;
        send_word(16'h8001, 1);
        send_word(16'h5A5A, 1);
        end_pkt();
        wait_drain();
        chk("post_rst_y_count", ny - y0, 32'd2);

        // Maximum length packet with random ack gaps on output_z.
        z0 = nz; done = 0;
        fork
            begin
                send_word(16'h00FF, 0);
                for (int i = 0; i < 255; i++) send_word(16'h1000 + 16'(i), 0);
                end_pkt();
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #2;
                    output_z_ack = 1'($urandom_range(0, 1));
                end
            end
        join
        output_z_ack = 1'b1;
        wait_drain();
        @(posedge clk); #2;
        chk("max_len_count", nz - z0, 32'd256);
        chk("max_len_hdr_rx", {31'd0, input_a_ack}, 32'd1);
        chk("max_len_no_stb", {30'd0, output_z_stb, output_y_stb}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/distributor.md
DISTRIBUTOR -- requirements
Module: distributor

Interface
REQ-001 SHALL have parameter: WIDTH, 16, data word width in bits; legal values are WIDTH >= 9.
REQ-002 SHALL have port: clk  in  1  rising-edge clock.
REQ-003 SHALL have port: rst  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port: input_a  in  WIDTH  inbound data word.
REQ-005 SHALL have port: input_a_stb  in  1  inbound word valid.
REQ-006 SHALL have port: input_a_ack  out  1  inbound word accepted.
REQ-007 SHALL have port: output_z  out  WIDTH  port-0 data word.
REQ-008 SHALL have port: output_z_stb  out  1  port-0 word valid.
REQ-009 SHALL have port: output_z_ack  in  1  port-0 word accepted.
REQ-010 SHALL have port: output_y  out  WIDTH  port-1 data word.
REQ-011 SHALL have port: output_y_stb  out  1  port-1 word valid.
REQ-012 SHALL have port: output_y_ack  in  1  port-1 word accepted.

Function
REQ-013 SHALL complete a transfer on a rising clk edge where stb and ack are both 1; stb/ack high alone transfers nothing.
REQ-014 SHALL treat the input as packets: one header word, then N payload words; N = header[7:0] (0..255); dest = header[WIDTH-1] (0 -> output_z, 1 -> output_y).
REQ-015 SHALL forward the header word unmodified to the selected port, then each payload word to the same port in order.
REQ-016 SHALL implement FSM states HDR_RX, HDR_TX, PAY_RX, PAY_TX.
REQ-017 SHALL drive input_a_ack = 1 exactly in HDR_RX and PAY_RX while rst = 0; it is 0 in all other states.
REQ-018 HDR_RX: on input transfer, latch the word into the holding register, latch dest and remaining = N, go to HDR_TX.
REQ-019 HDR_TX/PAY_TX: drive the holding register on both output data ports; drive stb = 1 on the selected port only.
REQ-020 HDR_TX/PAY_TX: on a selected-port transfer, go to PAY_RX if remaining > 0, else HDR_RX.
REQ-021 PAY_RX: on input transfer, latch the word, decrement remaining by 1, go to PAY_TX.
REQ-022 SHALL hold the word and stb steady while the selected ack is 0 (no timeout, no drop).
REQ-023 SHALL ignore the unselected port's ack in all states; an ack high before stb is ignored until stb rises.
REQ-024 Latency: input transfer at edge t -> selected stb = 1 in the cycle after t; 2 cycles per word at full throughput.
REQ-025 N = 0: header only; the FSM returns to HDR_RX after the header transfer.
REQ-026 Maximum length (N = 255): 256 output transfers, with no counter wrap.
REQ-027 SHALL latch dest once per packet; header bit WIDTH-1 of payload words has no routing effect.

Reset
REQ-028 rst = 1 at an edge SHALL force state = HDR_RX, remaining = 0, dest = 0, holding register = 0, overriding all other updates.
REQ-029 While rst = 1, all outputs SHALL be 0: input_a_ack = 0, both stb = 0, both data = 0.
REQ-030 Reset mid-packet SHALL discard the rest of the packet; the first word accepted after reset is a header.
REQ-031 Input transfers SHALL NOT occur while rst = 1.

Structure
REQ-032 Package distributor_pkg SHALL hold the FSM state enum, the DEST_BIT position (WIDTH-1), and the LEN_LSB/LEN_MSB constants (0/7).
REQ-033 The block SHALL be a single module with no sub-module; the FSM, 8-bit remaining counter, holding register and dest flag are local.
REQ-034 All outputs SHALL derive from registered state only; there is no combinational ack-to-stb path.

Verification
REQ-035 Header 0x0003 + payload 0x1111, 0x2222, 0x3333 with output_z_ack tied 1 -> output_z carries 0x0003, 0x1111, 0x2222, 0x3333; output_y_stb never 1; 8 cycles total.
REQ-036 Header 0x8000 (N = 0), then header 0x0001 + 0xABCD -> output_y gets 0x8000; output_z gets 0x0001, 0xABCD.
REQ-037 output_z_ack held 0 for 10 cycles during a payload word -> output_z_stb and data stay stable; input_a_ack stays 0; no word is lost.
REQ-038 output_y_ack pulsed high while dest = z -> no effect on state or outputs.
REQ-039 rst asserted after the 2nd payload word of an N = 5 packet, then 0x8001, 0x5A5A sent -> output_y gets 0x8001, 0x5A5A; outputs are 0 during rst.
REQ-040 Header 0x00FF + 255 payload words with random ack gaps -> exactly 256 output_z transfers in order, then input_a_ack = 1 in HDR_RX.
